// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand hazard FSM with cache freeze.
// Optional cycle counters enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_AW        = 5,
  parameter int BR_LOAD_STALL = 2,
  parameter int FLUSH_CYCLES  = 1,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_is_branch,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_memread,
  input  logic              redirect,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_flush,
  output logic [CNT_W-1:0]  perf_freeze
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } st_e;

  localparam logic [1:0] BRL   = 2'(BR_LOAD_STALL);
  localparam logic [1:0] FC_M1 = 2'(FLUSH_CYCLES - 1);

  st_e        state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] dem;
  logic       m_ex, m_mem, freeze;

  assign freeze   = icache_stall | dcache_stall;
  assign hz_state = state_q;

  // Operand matching and stall demand (largest active term wins)
  always_comb begin
    m_ex  = (ex_rd != '0) &&
            ((ex_rd == id_rs1 && id_rs1_used) ||
             (ex_rd == id_rs2 && id_rs2_used));
    m_mem = (mem_rd != '0) &&
            ((mem_rd == id_rs1 && id_rs1_used) ||
             (mem_rd == id_rs2 && id_rs2_used));
    dem = 2'd0;
    if (ex_memread && m_ex)
      dem = 2'd1;
    if (id_is_branch && ex_regwrite && !ex_memread && m_ex)
      dem = 2'd1;
    if (id_is_branch && mem_memread && m_mem)
      dem = 2'd1;
    if (id_is_branch && ex_memread && m_ex)
      dem = BRL;
  end

  // State and down-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a freeze holds state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        RUN: begin
          if (dem > 2'd1) begin
            state_d = STALL;
            cnt_d   = dem - 2'd1;
          end else if (dem == 2'd0 && redirect && FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FC_M1;
          end
        end
        STALL: begin
          if (cnt_q == 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        FLUSH: begin
          if (redirect) begin
            cnt_d = FC_M1;
          end else if (cnt_q == 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Control outputs: reset, freeze, stall, flush, normal in that order
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      pipe_freeze = 1'b1;
    end else if ((state_q == RUN && dem != 2'd0) ||
                 state_q == STALL) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end else if (redirect || state_q == FLUSH) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
  logic [CNT_W-1:0] perf_freeze_q, perf_freeze_d;

  // Saturating cycle counters
  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_flush_d  = perf_flush_q;
    perf_freeze_d = perf_freeze_q;
    if (idex_bubble && !(&perf_stall_q))
      perf_stall_d = perf_stall_q + 1'b1;
    if (ifid_flush && !(&perf_flush_q))
      perf_flush_d = perf_flush_q + 1'b1;
    if (pipe_freeze && !(&perf_freeze_q))
      perf_freeze_d = perf_freeze_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_flush_q  <= '0;
      perf_freeze_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_flush_q  <= perf_flush_d;
      perf_freeze_q <= perf_freeze_d;
    end
  end

  assign perf_stall  = perf_stall_q;
  assign perf_flush  = perf_flush_q;
  assign perf_freeze = perf_freeze_q;
`else
  assign perf_stall  = '0;
  assign perf_flush  = '0;
  assign perf_freeze = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl
// with BR_LOAD_STALL=2 and FLUSH_CYCLES=3.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_rs1_used, id_rs2_used, id_is_branch;
  logic        ex_regwrite, ex_memread, mem_memread;
  logic        redirect, icache_stall, dcache_stall;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze;
  logic [1:0]  hz_state;
  logic [31:0] perf_stall, perf_flush, perf_freeze;
  logic [4:0]  ov;

  int checks   = 0;
  int failures = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // out vector: pc_we ifid_we flush bubble freeze
  localparam logic [4:0] O_NORM = 5'b11000;
  localparam logic [4:0] O_STL  = 5'b00010;
  localparam logic [4:0] O_FLS  = 5'b11100;
  localparam logic [4:0] O_FRZ  = 5'b00001;
  localparam logic [4:0] O_RST  = 5'b00110;

  assign ov = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze};

  hazard_ctrl #(
    .REG_AW(5),
    .BR_LOAD_STALL(2),
    .FLUSH_CYCLES(3),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_is_branch(id_is_branch),
    .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread),
    .mem_rd(mem_rd),
    .mem_memread(mem_memread),
    .redirect(redirect),
    .icache_stall(icache_stall),
    .dcache_stall(dcache_stall),
    .pc_we(pc_we),
    .ifid_we(ifid_we),
    .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze),
    .hz_state(hz_state),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush),
    .perf_freeze(perf_freeze)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_is_branch = 1'b0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = '0; mem_memread = 1'b0;
    redirect = 1'b0;
    icache_stall = 1'b0; dcache_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk("rst_out", 32'(ov), 32'(O_RST));
    chk("rst_state", 32'(hz_state), 32'd0);
    chk("rst_pstall", perf_stall, 32'd0);
    rst = 1'b0;
    settle();
    chk("norm_out", 32'(ov), 32'(O_NORM));

    // load-use on rs2
    ex_memread = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_rs2_used = 1'b1;
    settle();
    chk("lu_out", 32'(ov), 32'(O_STL));
    tick();
    chk("lu_state", 32'(hz_state), 32'd0);
    idle();
    settle();
    chk("lu_after", 32'(ov), 32'(O_NORM));

    // load to x0 never stalls
    ex_memread = 1'b1; ex_rd = 5'd0;
    id_rs2 = 5'd0; id_rs2_used = 1'b1;
    settle();
    chk("lu_x0", 32'(ov), 32'(O_NORM));

    // operand not used: no stall
    ex_rd = 5'd6; id_rs2 = 5'd6; id_rs2_used = 1'b0;
    settle();
    chk("lu_unused", 32'(ov), 32'(O_NORM));
    idle();

    // branch on EX load: 2-cycle stall
    id_is_branch = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd7;
    settle();
    chk("bl_out0", 32'(ov), 32'(O_STL));
    tick();
    chk("bl_state1", 32'(hz_state), 32'd1);
    ex_memread = 1'b0; ex_rd = 5'd0;
    settle();
    chk("bl_out1", 32'(ov), 32'(O_STL));
    tick();
    chk("bl_state2", 32'(hz_state), 32'd0);
    chk("bl_out2", 32'(ov), 32'(O_NORM));
    idle();

    // branch on EX ALU result: 1 cycle
    id_is_branch = 1'b1; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    ex_regwrite = 1'b1; ex_rd = 5'd3;
    settle();
    chk("ba_out", 32'(ov), 32'(O_STL));
    tick();
    chk("ba_state", 32'(hz_state), 32'd0);

    // non-branch ALU dependency is forwarded
    id_is_branch = 1'b0;
    settle();
    chk("alu_fwd", 32'(ov), 32'(O_NORM));
    idle();

    // branch on MEM load: 1 cycle
    id_is_branch = 1'b1; id_rs2 = 5'd4; id_rs2_used = 1'b1;
    mem_memread = 1'b1; mem_rd = 5'd4;
    settle();
    chk("bm_out", 32'(ov), 32'(O_STL));
    tick();
    chk("bm_state", 32'(hz_state), 32'd0);
    idle();

    // jalr on x0 vs ex_rd=0
    id_is_branch = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    ex_regwrite = 1'b1; ex_rd = 5'd0;
    settle();
    chk("jalr_x0", 32'(ov), 32'(O_NORM));
    idle();

    // redirect masked by load-use
    ex_memread = 1'b1; ex_rd = 5'd9;
    id_rs1 = 5'd9; id_rs1_used = 1'b1;
    redirect = 1'b1;
    settle();
    chk("mask_out", 32'(ov), 32'(O_STL));
    tick();
    chk("mask_state", 32'(hz_state), 32'd0);
    idle();

    // redirect: 3 flush cycles
    redirect = 1'b1;
    settle();
    chk("rd_c1", 32'(ov), 32'(O_FLS));
    tick();
    chk("rd_st1", 32'(hz_state), 32'd2);
    redirect = 1'b0;
    settle();
    chk("rd_c2", 32'(ov), 32'(O_FLS));
    tick();
    chk("rd_c3", 32'(ov), 32'(O_FLS));
    chk("rd_st3", 32'(hz_state), 32'd2);
    tick();
    chk("rd_end_st", 32'(hz_state), 32'd0);
    chk("rd_end", 32'(ov), 32'(O_NORM));

    // second redirect in cycle 2: 4 flush cycles
    redirect = 1'b1;
    settle();
    chk("rr_c1", 32'(ov), 32'(O_FLS));
    tick();
    chk("rr_c2", 32'(ov), 32'(O_FLS));
    tick();
    redirect = 1'b0;
    settle();
    chk("rr_c3", 32'(ov), 32'(O_FLS));
    tick();
    chk("rr_c4", 32'(ov), 32'(O_FLS));
    chk("rr_st4", 32'(hz_state), 32'd2);
    tick();
    chk("rr_end", 32'(ov), 32'(O_NORM));
    chk("rr_end_st", 32'(hz_state), 32'd0);

    // clear counters, then freeze inside a stall
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_is_branch = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    ex_memread = 1'b1; ex_rd = 5'd7;
    settle();
    chk("fz_out0", 32'(ov), 32'(O_STL));
    tick();
    chk("fz_st0", 32'(hz_state), 32'd1);
    ex_memread = 1'b0; ex_rd = 5'd0;
    dcache_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("fz_out", 32'(ov), 32'(O_FRZ));
      tick();
      chk("fz_hold", 32'(hz_state), 32'd1);
    end
    dcache_stall = 1'b0;
    settle();
    chk("fz_bub", 32'(ov), 32'(O_STL));
    tick();
    chk("fz_end_st", 32'(hz_state), 32'd0);
    chk("fz_pstall", perf_stall, PERF ? 32'd2 : 32'd0);
    chk("fz_pfreeze", perf_freeze, PERF ? 32'd5 : 32'd0);
    chk("fz_pflush", perf_flush, 32'd0);
    idle();

    // reset in FLUSH aborts
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    chk("rf_st", 32'(hz_state), 32'd2);
    chk("rf_pflush", perf_flush, PERF ? 32'd2 : 32'd0);
    rst = 1'b1;
    settle();
    chk("rf_rst_out", 32'(ov), 32'(O_RST));
    tick();
    chk("rf_st_rst", 32'(hz_state), 32'd0);
    chk("rf_pflush0", perf_flush, 32'd0);
    chk("rf_pstall0", perf_stall, 32'd0);
    chk("rf_pfrz0", perf_freeze, 32'd0);
    rst = 1'b0;
    settle();
    chk("rf_post", 32'(ov), 32'(O_NORM));
    tick();
    chk("rf_post_st", 32'(hz_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage RISC-V core, replacing the purely combinational hazard detector in the IF/ID/EX control path. Detects load-use and branch-operand hazards, with x0 excluded and per-operand use flags. Holds multi-cycle stalls and mispredict flushes in a small FSM and freezes the whole pipeline on cache stalls. Optionally counts stall, flush and freeze cycles for performance analysis.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- BR_LOAD_STALL, 2: stall cycles for a branch/jalr in ID whose operand is a load in EX; legal range 1..3.
- FLUSH_CYCLES, 1: consecutive IF/ID flush cycles per redirect; legal range 1..4.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in IF/ID
- id_rs1_used, id_rs2_used  in  1  operand actually read (jal: both 0; jalr: rs1 only)
- id_is_branch  in  1  IF/ID holds a branch or jalr, resolved in ID
- ex_rd  in  REG_AW; ex_regwrite, ex_memread  in  1  ID/EX destination and controls
- mem_rd  in  REG_AW; mem_memread  in  1  EX/MEM destination and load flag
- redirect  in  1  PC redirect (taken branch, mispredict, jal/jalr)
- icache_stall, dcache_stall  in  1  cache miss in progress
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  clear IF/ID to a NOP
- idex_bubble  out  1  zero ID/EX control signals
- pipe_freeze  out  1  hold every pipeline register
- hz_state  out  2  FSM state: RUN=0, STALL=1, FLUSH=2
- perf_stall, perf_flush, perf_freeze  out  CNT_W  cycle counters

## Operation
- Operand match: `m(r) = (r != 0) && ((r == id_rs1 && id_rs1_used) || (r == id_rs2 && id_rs2_used))`.
- Stall demand, evaluated only in RUN; take the maximum of the active terms:
  - Load-use, `ex_memread && m(ex_rd)`: 1 cycle.
  - Branch on an EX ALU result, `id_is_branch && ex_regwrite && !ex_memread && m(ex_rd)`: 1 cycle.
  - Branch on an EX load, `id_is_branch && ex_memread && m(ex_rd)`: BR_LOAD_STALL cycles.
  - Branch on a MEM load, `id_is_branch && mem_memread && m(mem_rd)`: 1 cycle.
- Priority each cycle: freeze, then data stall, then redirect, then normal.
  - Freeze (`icache_stall | dcache_stall`): pipe_freeze=1, pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0. FSM state and down-counter hold.
  - Stall, in RUN with demand>0 or in STALL: pc_we=0, ifid_we=0, idex_bubble=1. redirect is masked.
  - Redirect, in RUN or FLUSH: pc_we=1, ifid_we=1, ifid_flush=1.
  - Normal: pc_we=1, ifid_we=1, all other outputs 0.
- FSM, 2-bit state plus 2-bit down-counter `cnt`:
  - RUN with demand D>1 goes to STALL with cnt=D-1.
  - RUN with redirect and FLUSH_CYCLES>1 goes to FLUSH with cnt=FLUSH_CYCLES-1.
  - STALL/FLUSH: if cnt==1, next state is RUN; otherwise cnt decrements.
  - In FLUSH, a new redirect reloads cnt=FLUSH_CYCLES-1. Data hazards are ignored because ID holds a bubble.
  - While STALL is held, IF/ID is stable; new demand is not re-evaluated until RUN.
- Reset (synchronous) sets state=RUN, cnt=0, counters=0. While rst=1, outputs are forced to pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0.
- Reset mid-STALL or mid-FLUSH aborts immediately; the first post-reset cycle is RUN.

## Timing
- All control outputs are combinational from the current state and inputs. There is zero-cycle latency from hazard to effect in the detecting cycle.
- A D-cycle stall asserts idex_bubble for exactly D non-frozen cycles. Frozen cycles stretch the sequence without consuming it.
- A redirect flushes IF/ID for exactly FLUSH_CYCLES non-frozen cycles, starting in the redirect cycle.
- hz_state and the counters update on the rising clk edge.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - perf_stall increments on each cycle with idex_bubble=1.
  - perf_flush increments on each cycle with ifid_flush=1 outside reset.
  - perf_freeze increments on each cycle with pipe_freeze=1.
  - Each counter saturates at all-ones; rst clears them.
- HAZARD_PERF_CNT_EN undefined: the counter registers are not built and all three perf outputs are tied to 0.

## Test plan
- lw x5 in EX (ex_memread=1, ex_rd=5), add using rs2=x5 -> one cycle of idex_bubble=1, pc_we=0, then RUN. Same case with ex_rd=0 -> no stall.
- beq rs1=x7 with lw x7 in EX, BR_LOAD_STALL=2 -> hz_state RUN→STALL→RUN, bubble for exactly 2 cycles.
- beq on an ALU result in EX (ex_regwrite=1, ex_memread=0, match) -> 1 stall cycle. jalr using rs1=x0 against ex_rd=0 -> no stall.
- redirect=1 with FLUSH_CYCLES=3 -> ifid_flush=1 for 3 cycles. A second redirect in cycle 2 -> flush extends to 4 total cycles.
- dcache_stall=1 for 5 cycles during a STALL with cnt=1 -> pipe_freeze=1 for 5 cycles, hz_state held, then 1 more bubble cycle. With HAZARD_PERF_CNT_EN: perf_freeze=5, perf_stall=2.
- rst=1 asserted in FLUSH -> next cycle hz_state=0, counters 0. Outputs during reset: ifid_flush=1, idex_bubble=1.
